// File: rtl/wb_dma_engine.sv
// Wishbone DMA initiator: CPU-programmed word copy from SRC to DST, staged through a
// BURST-deep buffer (read phase, then write phase) over a classic single-transfer master port.
module wb_dma_engine #(
  parameter int BURST = 4,
  parameter int LEN_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        irq_o
);
  localparam int IW = $clog2(BURST + 1);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]        len_q, len_d, rem_q, rem_d;
  logic [31:0]             srcp_q, srcp_d, dstp_q, dstp_d;
  logic                    done_q, done_d, irq_en_q, irq_en_d;
  logic                    ack_q, ack_d;
  logic [31:0]             rdat_q, rdat_d;
  logic                    stb_q, stb_d, we_q, we_d;
  logic [31:0]             adr_q, adr_d, wdat_q, wdat_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BURST-1:0][31:0]  buf_q, buf_d;

  logic                    busy, cfg_wr, last;
  logic [LEN_W-1:0]        chunk;
  logic [BW-1:0]           bi;
  logic                    unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    srcp_d   = srcp_q;
    dstp_d   = dstp_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    buf_d    = buf_q;
    stb_d    = stb_q;
    we_d     = we_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    busy     = (state_q != IDLE);
    chunk    = (rem_q >= LEN_W'(BURST)) ? LEN_W'(BURST) : rem_q;
    last     = (LEN_W'(idx_q) + LEN_W'(1)) == chunk;
    bi       = idx_q[BW-1:0];

    ack_d  = wbs_cyc_i & wbs_stb_i & ~ack_q;
    rdat_d = '0;
    if (ack_d && !wbs_we_i) begin
      case (wbs_adr_i[3:2])
        2'd0:    rdat_d = {28'd0, irq_en_q, busy, done_q, 1'b0};
        2'd1:    rdat_d = src_q;
        2'd2:    rdat_d = dst_q;
        default: rdat_d = 32'(len_q);
      endcase
    end

    // Writes commit in the ack cycle, while the CPU still holds the request.
    cfg_wr = wbs_cyc_i & wbs_stb_i & wbs_we_i & ack_q;
    if (cfg_wr) begin
      case (wbs_adr_i[3:2])
        2'd0: begin
          irq_en_d = wbs_dat_i[3];
          if (wbs_dat_i[1]) done_d = 1'b0;
          if (wbs_dat_i[0] && !busy) begin
            done_d  = 1'b0;
            srcp_d  = {src_q[31:2], 2'b00};
            dstp_d  = {dst_q[31:2], 2'b00};
            rem_d   = len_q;
            idx_d   = '0;
            state_d = (len_q == '0) ? FIN : READ;
          end
        end
        2'd1:    if (!busy) src_d = wbs_dat_i;
        2'd2:    if (!busy) dst_d = wbs_dat_i;
        default: if (!busy) len_d = wbs_dat_i[LEN_W-1:0];
      endcase
    end

    case (state_q)
      READ, WRITE: begin
        if (stb_q) begin
          if (wbm_ack_i) begin
            stb_d = 1'b0;
            we_d  = 1'b0;
            if (state_q == READ) buf_d[bi] = wbm_dat_i;
            if (last) begin
              idx_d = '0;
              if (state_q == READ) begin
                state_d = WRITE;
              end else begin
                srcp_d  = srcp_q + 32'({chunk, 2'b00});
                dstp_d  = dstp_q + 32'({chunk, 2'b00});
                rem_d   = rem_q - chunk;
                state_d = (rem_q == chunk) ? FIN : READ;
              end
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end else begin
          // Strobe low here is the mandatory one-cycle gap; issue the next beat.
          stb_d  = 1'b1;
          we_d   = (state_q == WRITE);
          adr_d  = (state_q == WRITE) ? {dstp_q[31:2] + 30'(idx_q), 2'b00}
                                      : {srcp_q[31:2] + 30'(idx_q), 2'b00};
          wdat_d = buf_q[bi];
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      srcp_q   <= '0;
      dstp_q   <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      srcp_q   <= srcp_d;
      dstp_q   <= dstp_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      buf_q    <= buf_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign wbm_cyc_o = stb_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;
  assign irq_o     = done_q & irq_en_q;
endmodule
